// File: rtl/weight_ram_sequencer.sv
// Weight RAM sequencer: fires the RAM init strobe after reset, streams the
// weight banks to the neuron datapath under valid/ready, and grants bank
// write-backs between passes. Every output comes straight from a register.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_INIT | first cycle raises RamIn, second cycle drops it and leaves
// S_IDLE | waiting; WrReq beats Start, bad WrBank answered with WrErr
// S_RD   | presenting bank_q: bubble cycle, then RdValid until RdReady
// S_WR   | single write cycle: RamWE and WrAck high at the bank base
module weight_ram_sequencer #(
   parameter int NUM_BANKS   = 3,
   parameter int BANK_STRIDE = 10,
   parameter int ADDR_W      = 5,
   parameter int BANK_W      = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              rd_ready_i,
   input  logic              wr_req_i,
   input  logic [BANK_W-1:0] wr_bank_i,
   output logic              ram_in_o,
   output logic [ADDR_W-1:0] ram_address_o,
   output logic              ram_we_o,
   output logic              rd_valid_o,
   output logic [BANK_W-1:0] rd_bank_o,
   output logic              done_o,
   output logic              wr_ack_o,
   output logic              wr_err_o,
   output logic              busy_o
);

   localparam logic [1:0] S_INIT = 2'd0;
   localparam logic [1:0] S_IDLE = 2'd1;
   localparam logic [1:0] S_RD   = 2'd2;
   localparam logic [1:0] S_WR   = 2'd3;

   localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);
   localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(BANK_STRIDE);

   logic [1:0]        state_q, state_d;
   logic              ram_in_q, ram_in_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic              valid_q, valid_d;
   logic [BANK_W-1:0] bank_q, bank_d;
   logic              done_q, done_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;

   // Base word of a bank; the largest base plus a full bank still fits, so no wrap.
   function automatic logic [ADDR_W-1:0] bank_base(input logic [BANK_W-1:0] b);
      return {{(ADDR_W-BANK_W){1'b0}}, b} * STRIDE;
   endfunction

   // Next-state and next-output decode; pulses default low every cycle.
   always_comb begin
      state_d  = state_q;
      ram_in_d = 1'b0;
      addr_d   = addr_q;
      we_d     = 1'b0;
      valid_d  = valid_q;
      bank_d   = bank_q;
      done_d   = 1'b0;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      busy_d   = busy_q;
      case (state_q)
         S_INIT: begin
            if (!ram_in_q) begin
               ram_in_d = 1'b1;
               busy_d   = 1'b1;
            end else begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end
         end
         S_IDLE: begin
            addr_d  = '0;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            bank_d  = '0;
            if (wr_req_i) begin
               if (wr_bank_i <= LAST_BANK) begin
                  state_d = S_WR;
                  we_d    = 1'b1;
                  addr_d  = bank_base(wr_bank_i);
                  ack_d   = 1'b1;
                  busy_d  = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end else if (start_i) begin
               state_d = S_RD;
               busy_d  = 1'b1;
            end
         end
         S_WR: begin
            state_d = S_IDLE;
            addr_d  = '0;
            busy_d  = 1'b0;
         end
         S_RD: begin
            // Address has been on the RAM for one cycle once valid rises.
            if (!valid_q) begin
               valid_d = 1'b1;
            end else if (rd_ready_i) begin
               valid_d = 1'b0;
               if (bank_q == LAST_BANK) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                  addr_d  = '0;
                  bank_d  = '0;
                  busy_d  = 1'b0;
               end else begin
                  bank_d = bank_q + 1'b1;
                  addr_d = bank_base(bank_q + 1'b1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; reset drops any pending pulse and re-arms init.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_INIT;
         ram_in_q <= 1'b0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         valid_q  <= 1'b0;
         bank_q   <= '0;
         done_q   <= 1'b0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ram_in_q <= ram_in_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         valid_q  <= valid_d;
         bank_q   <= bank_d;
         done_q   <= done_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
      end
   end

   assign ram_in_o      = ram_in_q;
   assign ram_address_o = addr_q;
   assign ram_we_o      = we_q;
   assign rd_valid_o    = valid_q;
   assign rd_bank_o     = bank_q;
   assign done_o        = done_q;
   assign wr_ack_o      = ack_q;
   assign wr_err_o      = err_q;
   assign busy_o        = busy_q;

endmodule

// File: tb/tb_weight_ram_sequencer.sv
// Bench for weight_ram_sequencer. Transactions (init, write, pass) expand into
// a plan of per-cycle inputs and expected outputs; a small RAM model sits on
// the control outputs so bank data on Q can be checked against written data.
module tb_weight_ram_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, wr_req, rd_ready;
   logic [1:0] wr_bank;
   logic       ram_in_o, ram_we_o, rd_valid_o, done_o, wr_ack_o, wr_err_o, busy_o;
   logic [4:0] ram_address_o;
   logic [1:0] rd_bank_o;

   int n_tests = 0;
   int n_fail  = 0;

   weight_ram_sequencer dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .rd_ready_i(rd_ready),
      .wr_req_i(wr_req), .wr_bank_i(wr_bank), .ram_in_o(ram_in_o),
      .ram_address_o(ram_address_o), .ram_we_o(ram_we_o), .rd_valid_o(rd_valid_o),
      .rd_bank_o(rd_bank_o), .done_o(done_o), .wr_ack_o(wr_ack_o),
      .wr_err_o(wr_err_o), .busy_o(busy_o)
   );

   // Behavioural RAM: 30 words of 10 bits, registered read of 10 words.
   logic [99:0] d_bus;
   logic [99:0] q_bank;
   logic [9:0]  mem [0:29];
   logic [99:0] ref_bank [0:2];

   always @(posedge clk) begin
      for (int i = 0; i < 30; i++) begin
         if (ram_in_o) mem[i] <= 10'((i * 37 + 5) % 1024);
      end
      for (int i = 0; i < 10; i++) begin
         int a;
         a = int'(ram_address_o) + i;
         if (!ram_in_o && ram_we_o && a < 30) mem[a] <= d_bus[i*10 +: 10];
         q_bank[i*10 +: 10] <= (a < 30) ? mem[a] : 10'h0;
      end
   end

   function automatic logic [99:0] init_bank(int b);
      logic [99:0] r;
      for (int i = 0; i < 10; i++) r[i*10 +: 10] = 10'(((b * 10 + i) * 37 + 5) % 1024);
      return r;
   endfunction

   typedef struct {
      logic       start, wr_req, rd_ready;
      logic [1:0] wr_bank;
      logic       e_in, e_we, e_valid, e_done, e_ack, e_err, e_busy;
      logic [4:0] e_addr;
      logic [1:0] e_bank;
   } ent_t;

   ent_t plan [$];

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [1:0] rb2();
      return 2'($urandom_range(0, 3));
   endfunction

   // Entry with given inputs and an all-quiet (idle) expectation.
   function automatic ent_t mk(logic st, logic wr, logic rdy, logic [1:0] wb);
      ent_t e;
      e = '{default: '0};
      e.start = st; e.wr_req = wr; e.rd_ready = rdy; e.wr_bank = wb;
      return e;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_q(string name, logic [99:0] act, logic [99:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // The single compare process: one plan entry per clock cycle.
   task automatic run_q();
      ent_t e;
      while (plan.size() > 0) begin
         e = plan.pop_front();
         start = e.start; wr_req = e.wr_req; rd_ready = e.rd_ready; wr_bank = e.wr_bank;
         @(posedge clk);
         #1;
         chk("ram_in", 32'(ram_in_o), 32'(e.e_in));
         chk("ram_address", 32'(ram_address_o), 32'(e.e_addr));
         chk("ram_we", 32'(ram_we_o), 32'(e.e_we));
         chk("rd_valid", 32'(rd_valid_o), 32'(e.e_valid));
         chk("done", 32'(done_o), 32'(e.e_done));
         chk("wr_ack", 32'(wr_ack_o), 32'(e.e_ack));
         chk("wr_err", 32'(wr_err_o), 32'(e.e_err));
         chk("busy", 32'(busy_o), 32'(e.e_busy));
         if (e.e_valid) begin
            chk("rd_bank", 32'(rd_bank_o), 32'(e.e_bank));
            chk_q("ram_q", q_bank, ref_bank[e.e_bank]);
         end
      end
   endtask

   task automatic do_init();
      ent_t e;
      e = mk(rb(), rb(), rb(), rb2());
      e.e_in = 1'b1; e.e_busy = 1'b1;
      plan.push_back(e);
      run_q();
      chk("init_lit_ram_in", 32'(ram_in_o), 32'd1);
      chk("init_lit_ram_we", 32'(ram_we_o), 32'd0);
      plan.push_back(mk(rb(), rb(), rb(), rb2()));
      run_q();
      for (int b = 0; b < 3; b++) ref_bank[b] = init_bank(b);
   endtask

   task automatic do_write(logic [1:0] b, logic st);
      ent_t e;
      logic [127:0] t;
      e = mk(st, 1'b1, rb(), b);
      if (b < 2'd3) begin
         t = {$urandom, $urandom, $urandom, $urandom};
         d_bus = t[99:0];
         e.e_we = 1'b1; e.e_ack = 1'b1; e.e_busy = 1'b1;
         e.e_addr = 5'(int'(b) * 10);
         ref_bank[b] = d_bus;
      end else begin
         e.e_err = 1'b1;
      end
      plan.push_back(e);
      run_q();
      if (b == 2'd2) begin
         chk("wr2_lit_addr", 32'(ram_address_o), 32'd20);
         chk("wr2_lit_we", 32'(ram_we_o), 32'd1);
      end
      if (b == 2'd3) chk("wr3_lit_we", 32'(ram_we_o), 32'd0);
      if (b < 2'd3) begin
         plan.push_back(mk(rb(), rb(), rb(), rb2()));
         run_q();
      end
   endtask

   // One read pass; stops while presenting bank 'upto' when upto < 3.
   task automatic do_pass(int stall_b, int stall_n, bit rnd_stalls, int upto);
      ent_t e;
      int n;
      e = mk(1'b1, 1'b0, rb(), rb2());
      e.e_busy = 1'b1;
      plan.push_back(e);
      for (int b = 0; b < 3; b++) begin
         e = mk(rb(), rb(), rb(), rb2());
         e.e_valid = 1'b1; e.e_busy = 1'b1;
         e.e_addr = 5'(b * 10); e.e_bank = 2'(b);
         plan.push_back(e);
         n = (b == stall_b) ? stall_n : (rnd_stalls ? int'($urandom_range(0, 2)) : 0);
         for (int s = 0; s < n; s++) begin
            e.start = rb(); e.wr_req = rb(); e.rd_ready = 1'b0; e.wr_bank = rb2();
            plan.push_back(e);
         end
         if (b == upto) begin
            run_q();
            return;
         end
         e = mk(rb(), rb(), 1'b1, rb2());
         if (b < 2) begin
            e.e_busy = 1'b1; e.e_addr = 5'((b + 1) * 10);
         end else begin
            e.e_done = 1'b1;
         end
         plan.push_back(e);
      end
      run_q();
   endtask

   task automatic chk_all_zero(string tag);
      chk({tag, "_ram_in"}, 32'(ram_in_o), 32'd0);
      chk({tag, "_ram_address"}, 32'(ram_address_o), 32'd0);
      chk({tag, "_ram_we"}, 32'(ram_we_o), 32'd0);
      chk({tag, "_rd_valid"}, 32'(rd_valid_o), 32'd0);
      chk({tag, "_rd_bank"}, 32'(rd_bank_o), 32'd0);
      chk({tag, "_done"}, 32'(done_o), 32'd0);
      chk({tag, "_wr_ack"}, 32'(wr_ack_o), 32'd0);
      chk({tag, "_wr_err"}, 32'(wr_err_o), 32'd0);
      chk({tag, "_busy"}, 32'(busy_o), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; wr_req = 1'b0; rd_ready = 1'b0; wr_bank = 2'd0;
      d_bus = '0;
      for (int b = 0; b < 3; b++) ref_bank[b] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      do_init();

      do_pass(-1, 0, 1'b0, 3);
      do_pass(1, 5, 1'b0, 3);
      do_write(2'd2, 1'b0);
      do_pass(-1, 0, 1'b1, 3);
      do_write(2'd3, 1'b0);
      do_write(2'd0, 1'b1);
      do_pass(-1, 0, 1'b1, 3);

      repeat (40) begin
         case ($urandom_range(0, 3))
            0: repeat ($urandom_range(1, 3)) begin
                  plan.push_back(mk(1'b0, 1'b0, rb(), rb2()));
                  run_q();
               end
            1: do_write(rb2(), rb());
            default: do_pass(-1, 0, 1'b1, 3);
         endcase
      end

      do_write(2'd1, 1'b0);
      do_pass(-1, 0, 1'b0, 1);
      #2;
      rst = 1'b1;
      #1;
      chk_all_zero("midpass_reset");
      @(posedge clk);
      #1;
      chk_all_zero("held_reset");
      @(negedge clk);
      rst = 1'b0; start = 1'b0; wr_req = 1'b0;
      do_init();
      do_pass(-1, 0, 1'b1, 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
